// File: rtl/tile_scheduler.sv
// Frame tile dispatcher: hands 16x16 tiles to idle SMs round-robin and funnels
// their finished rows through a single registered framebuffer write stage.
module tile_scheduler #(
  parameter int NUM_SM  = 4,
  parameter int TILES_X = 40,
  parameter int TILES_Y = 30,
  parameter int ADDR_W  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_frame_start,
  input  logic [NUM_SM-1:0]       i_sm_req,
  output logic [NUM_SM-1:0]       o_grant,
  output logic [5:0]              o_tile_x,
  output logic [5:0]              o_tile_y,
  input  logic [NUM_SM-1:0]       i_wb_valid,
  input  logic [4*NUM_SM-1:0]     i_wb_row,
  input  logic [256*NUM_SM-1:0]   i_wb_data,
  output logic [NUM_SM-1:0]       o_wb_ready,
  output logic                    o_fb_valid,
  output logic [ADDR_W-1:0]       o_fb_addr,
  output logic [255:0]            o_fb_data,
  input  logic                    i_fb_ready,
  output logic                    o_frame_done,
  output logic                    o_busy
);

  localparam int PTR_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;
  localparam int OUT_W = $clog2(NUM_SM + 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [5:0]          cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [PTR_W-1:0]    dsp_ptr_q, dsp_ptr_d, wb_ptr_q, wb_ptr_d;
  logic [NUM_SM-1:0]   busy_q, busy_d;
  logic [5:0]          tx_q [NUM_SM];
  logic [5:0]          tx_d [NUM_SM];
  logic [5:0]          ty_q [NUM_SM];
  logic [5:0]          ty_d [NUM_SM];
  logic [4:0]          rcnt_q [NUM_SM];
  logic [4:0]          rcnt_d [NUM_SM];
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic [NUM_SM-1:0]   grant_q, grant_d;
  logic [5:0]          gx_q, gx_d, gy_q, gy_d;
  logic                fb_valid_q, fb_valid_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [255:0]        fb_data_q, fb_data_d;

  logic [NUM_SM-1:0]   dsp_oh, wb_oh;
  logic [PTR_W-1:0]    dsp_idx, wb_idx;
  logic                wb_en, done_one;

  // First candidate at or after ptr, scanning upward with wrap.
  function automatic logic [NUM_SM-1:0] rr_pick(input logic [NUM_SM-1:0] cand,
                                                input logic [PTR_W-1:0]  ptr);
    logic [NUM_SM-1:0] pick;
    int idx;
    pick = '0;
    for (int k = NUM_SM - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_SM;
      if (cand[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] enc(input logic [NUM_SM-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SM; i++)
      if (oh[i]) idx = PTR_W'(i);
    return idx;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (int'(idx) == NUM_SM - 1) ? '0 : idx + PTR_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    dsp_ptr_d  = dsp_ptr_q;
    wb_ptr_d   = wb_ptr_q;
    busy_d     = busy_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    rcnt_d     = rcnt_q;
    outst_d    = outst_q;
    grant_d    = '0;
    gx_d       = gx_q;
    gy_d       = gy_q;
    fb_valid_d = fb_valid_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    done_one   = 1'b0;

    dsp_oh  = rr_pick((state_q == DISPATCH) ? (i_sm_req & ~busy_q) : '0, dsp_ptr_q);
    dsp_idx = enc(dsp_oh);
    wb_en   = !fb_valid_q || i_fb_ready;
    wb_oh   = wb_en ? rr_pick((state_q != IDLE) ? (i_wb_valid & busy_q) : '0, wb_ptr_q) : '0;
    wb_idx  = enc(wb_oh);

    if (|dsp_oh) begin
      grant_d   = dsp_oh;
      gx_d      = cur_x_q;
      gy_d      = cur_y_q;
      dsp_ptr_d = next_ptr(dsp_idx);
      busy_d[dsp_idx] = 1'b1;
      rcnt_d[dsp_idx] = '0;
      tx_d[dsp_idx]   = cur_x_q;
      ty_d[dsp_idx]   = cur_y_q;
      if (cur_x_q == 6'(TILES_X - 1)) begin
        cur_x_d = '0;
        cur_y_d = cur_y_q + 6'd1;
        if (cur_y_q == 6'(TILES_Y - 1)) state_d = DRAIN;
      end else begin
        cur_x_d = cur_x_q + 6'd1;
      end
    end

    // The output stage drains on ready and refills in the same cycle on accept.
    if (i_fb_ready) fb_valid_d = 1'b0;
    if (|wb_oh) begin
      wb_ptr_d   = next_ptr(wb_idx);
      fb_valid_d = 1'b1;
      fb_addr_d  = ADDR_W'((int'(ty_q[wb_idx]) * 16 + int'(i_wb_row[4*int'(wb_idx) +: 4]))
                           * TILES_X + int'(tx_q[wb_idx]));
      fb_data_d  = i_wb_data[256*int'(wb_idx) +: 256];
      rcnt_d[wb_idx] = rcnt_q[wb_idx] + 5'd1;
      if (rcnt_q[wb_idx] == 5'd15) begin
        busy_d[wb_idx] = 1'b0;
        done_one       = 1'b1;
      end
    end

    if ((|dsp_oh) && !done_one) outst_d = outst_q + OUT_W'(1);
    if (!(|dsp_oh) && done_one) outst_d = outst_q - OUT_W'(1);

    case (state_q)
      IDLE: if (i_frame_start) begin
        state_d = DISPATCH;
        cur_x_d = '0;
        cur_y_d = '0;
      end
      DRAIN: if (outst_q == '0 && !fb_valid_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      dsp_ptr_q  <= '0;
      wb_ptr_q   <= '0;
      busy_q     <= '0;
      outst_q    <= '0;
      grant_q    <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
      fb_valid_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      for (int i = 0; i < NUM_SM; i++) begin
        tx_q[i]   <= '0;
        ty_q[i]   <= '0;
        rcnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      dsp_ptr_q  <= dsp_ptr_d;
      wb_ptr_q   <= wb_ptr_d;
      busy_q     <= busy_d;
      outst_q    <= outst_d;
      grant_q    <= grant_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      fb_valid_q <= fb_valid_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_tile_x     = gx_q;
  assign o_tile_y     = gy_q;
  assign o_wb_ready   = wb_oh;
  assign o_fb_valid   = fb_valid_q;
  assign o_fb_addr    = fb_addr_q;
  assign o_fb_data    = fb_data_q;
  assign o_frame_done = (state_q == DONE);
  assign o_busy       = (state_q != IDLE);

endmodule
